// File: rtl/spi_coeff_loader.sv
// SPI responder that captures 5-word biquad coefficient frames into a shadow bank
// and commits them atomically to the filter on a sample boundary; sdo reads back the active set.
module spi_coeff_loader #(
    parameter int unsigned COEFF_W     = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESET_B0    = 16384
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sck,
    input  logic                      sdi,
    input  logic                      cs_n,
    output logic                      sdo,
    input  logic                      sample_strobe,
    output logic signed [COEFF_W-1:0] b0,
    output logic signed [COEFF_W-1:0] b1,
    output logic signed [COEFF_W-1:0] b2,
    output logic signed [COEFF_W-1:0] a1,
    output logic signed [COEFF_W-1:0] a2,
    output logic                      coeff_update,
    output logic                      frame_error
);

    localparam int unsigned FRAME_W = 5 * COEFF_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam int unsigned WAIT_W  = $clog2(SYNC_STAGES + 1);
    localparam logic [FRAME_W-1:0] RESET_BANK = {COEFF_W'(RESET_B0), {(4 * COEFF_W){1'b0}}};

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t               state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                 sck_prev_q;
    logic                 cs_prev_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_W-1:0]   shift_q;
    logic [FRAME_W-1:0]   rb_q;
    logic [FRAME_W-1:0]   shadow_q;
    logic [FRAME_W-1:0]   active_q;
    logic                 pending_q;
    logic                 sdo_q;
    logic                 upd_q;
    logic                 err_q;

    logic sck_s, sdi_s, cs_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_IDLE;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            wait_q     <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            rb_q       <= '0;
            shadow_q   <= '0;
            active_q   <= RESET_BANK;
            pending_q  <= 1'b0;
            sdo_q      <= 1'b0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;

            // Commit uses the pending flag from before this edge; a frame landing now waits.
            if (sample_strobe && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
                upd_q     <= 1'b1;
            end

            case (state_q)
                WAIT_IDLE: begin
                    // The cs_n chain resets high, so demand enough high samples to flush it.
                    sdo_q <= 1'b0;
                    if (!cs_s) begin
                        wait_q <= '0;
                    end else if (wait_q == WAIT_W'(SYNC_STAGES)) begin
                        wait_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                IDLE: begin
                    sdo_q <= 1'b0;
                    if (cs_fall) begin
                        cnt_q   <= '0;
                        rb_q    <= active_q;
                        sdo_q   <= active_q[FRAME_W-1];
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        sdo_q   <= 1'b0;
                        state_q <= IDLE;
                        if (cnt_q == CNT_W'(FRAME_W)) begin
                            shadow_q  <= shift_q;
                            pending_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        if (sck_rise) begin
                            shift_q <= {shift_q[FRAME_W-2:0], sdi_s};
                            if (cnt_q != CNT_W'(FRAME_W + 1)) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        if (sck_fall) begin
                            rb_q  <= {rb_q[FRAME_W-2:0], 1'b0};
                            sdo_q <= rb_q[FRAME_W-2];
                        end
                    end
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign sdo          = sdo_q;
    assign coeff_update = upd_q;
    assign frame_error  = err_q;
    assign b0           = active_q[5*COEFF_W-1 -: COEFF_W];
    assign b1           = active_q[4*COEFF_W-1 -: COEFF_W];
    assign b2           = active_q[3*COEFF_W-1 -: COEFF_W];
    assign a1           = active_q[2*COEFF_W-1 -: COEFF_W];
    assign a2           = active_q[COEFF_W-1 -: COEFF_W];

endmodule

// File: tb/tb_spi_coeff_loader.sv
// Self-checking bench for spi_coeff_loader: frame-level reference model of the
// shadow/active banks, commit rules and readback, driven by directed and random frames.
module tb_spi_coeff_loader;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset, sck, sdi, cs_n, sdo, sample_strobe, coeff_update, frame_error;
    logic signed [15:0] b0, b1, b2, a1, a2;
    logic [15:0] dut_c [5];

    always #5 clk = ~clk;

    spi_coeff_loader dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n), .sdo(sdo),
        .sample_strobe(sample_strobe), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .coeff_update(coeff_update), .frame_error(frame_error)
    );

    always_comb begin
        dut_c[0] = b0; dut_c[1] = b1; dut_c[2] = b2; dut_c[3] = a1; dut_c[4] = a2;
    end

    // Reference model: whole-frame view of the coefficient banks
    logic [15:0] m_active [5];
    logic [15:0] m_shadow [5];
    bit m_pending;
    int exp_upd = 0, exp_err = 0, upd_cnt = 0, err_cnt = 0;
    int n_checks = 0, n_pass = 0;

    always @(negedge clk) begin
        if (coeff_update === 1'b1) upd_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    function automatic logic [79:0] active_word();
        return {m_active[0], m_active[1], m_active[2], m_active[3], m_active[4]};
    endfunction

    task automatic model_reset();
        m_active[0] = 16'h4000;
        for (int k = 1; k < 5; k++) m_active[k] = 16'h0000;
        for (int k = 0; k < 5; k++) m_shadow[k] = 16'h0000;
        m_pending = 1'b0;
    endtask

    task automatic model_frame(input logic [79:0] d, input int nbits);
        if (nbits == 80) begin
            for (int k = 0; k < 5; k++) m_shadow[k] = d[79-16*k -: 16];
            m_pending = 1'b1;
        end else begin
            exp_err++;
        end
    endtask

    task automatic model_strobe();
        if (m_pending) begin
            for (int k = 0; k < 5; k++) m_active[k] = m_shadow[k];
            m_pending = 1'b0;
            exp_upd++;
        end
    endtask

    task automatic do_strobe();
        @(negedge clk) sample_strobe = 1'b1;
        @(negedge clk) sample_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Mode-0 master: sdi changes while sck is low, sdo sampled just before each rise
    task automatic shift_bits(input logic [79:0] d, input int nbits, input bit lower_cs,
                              input bit raise_cs, output logic [79:0] rb);
        rb = '0;
        if (lower_cs) begin
            @(negedge clk) cs_n = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            sdi = (i < 80) ? d[79-i] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            if (i < 80) rb[79-i] = sdo;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (raise_cs) begin
            cs_n = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1; sample_strobe = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL reset_coeff[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (sdo !== 1'b0) $display("FAIL reset_sdo got %b exp 0", sdo); else n_pass++;
        n_checks++;
        if (coeff_update !== 1'b0) $display("FAIL reset_update got %b exp 0", coeff_update); else n_pass++;
        n_checks++;
        if (frame_error !== 1'b0) $display("FAIL reset_error got %b exp 0", frame_error); else n_pass++;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_readback();
        logic [79:0] rb;
        shift_bits(80'h0, 80, 1'b1, 1'b1, rb);
        model_frame(80'h0, 80);
        n_checks++;
        if (rb !== {16'h4000, 64'h0}) $display("FAIL readback got %h exp %h", rb, {16'h4000, 64'h0});
        else n_pass++;
        n_checks++;
        if (sdo !== 1'b0) $display("FAIL sdo_idle got %b exp 0", sdo); else n_pass++;
        do_strobe();
        model_strobe();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL readback_commit[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL readback_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
    endtask

    task automatic test_valid_frame();
        logic [79:0] rb;
        logic [79:0] d = {16'h2000, 16'h4000, 16'h2000, 16'hC000, 16'h1000};
        shift_bits(d, 80, 1'b1, 1'b1, rb);
        model_frame(d, 80);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL pre_strobe[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        do_strobe();
        model_strobe();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL valid_commit[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL valid_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
    endtask

    task automatic test_bad_frames();
        logic [79:0] rb;
        int lens [3] = '{79, 81, 0};
        for (int j = 0; j < 3; j++) begin
            logic [79:0] d = {16'($urandom), 32'($urandom), 32'($urandom)};
            shift_bits(d, lens[j], 1'b1, 1'b1, rb);
            model_frame(d, lens[j]);
            n_checks++;
            if (err_cnt !== exp_err) $display("FAIL bad_frame_error len %0d got %0d exp %0d", lens[j], err_cnt, exp_err);
            else n_pass++;
        end
        do_strobe();
        model_strobe();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL bad_hold[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL bad_no_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [79:0] rb;
        shift_bits({5{16'h1111}}, 80, 1'b1, 1'b1, rb);
        model_frame({5{16'h1111}}, 80);
        shift_bits({5{16'h2222}}, 80, 1'b1, 1'b1, rb);
        model_frame({5{16'h2222}}, 80);
        do_strobe(); model_strobe();
        do_strobe(); model_strobe();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL b2b_coeff[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL b2b_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
    endtask

    task automatic test_strobe_same_cycle();
        logic [79:0] rb;
        logic [79:0] d = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h7FFF};
        shift_bits(d, 80, 1'b1, 1'b0, rb);
        // The frame completes three clocks after cs_n rises; strobe lands on that edge
        @(negedge clk) cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk) sample_strobe = 1'b1;
        @(negedge clk) sample_strobe = 1'b0;
        model_strobe();
        model_frame(d, 80);
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL same_cycle_hold[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL same_cycle_no_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
        do_strobe(); model_strobe();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL same_cycle_commit[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL same_cycle_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [79:0] rb;
        logic [79:0] d = {16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0, 16'h3C3C};
        shift_bits(d, 40, 1'b1, 1'b0, rb);
        do_reset();
        shift_bits({d[39:0], 40'h0}, 40, 1'b0, 1'b1, rb);
        do_strobe(); model_strobe();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL midreset_coeff[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (err_cnt !== exp_err) $display("FAIL midreset_error got %0d exp %0d", err_cnt, exp_err); else n_pass++;
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL midreset_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
        shift_bits(d, 80, 1'b1, 1'b1, rb);
        model_frame(d, 80);
        n_checks++;
        if (rb !== {16'h4000, 64'h0}) $display("FAIL midreset_readback got %h exp %h", rb, {16'h4000, 64'h0});
        else n_pass++;
        do_strobe(); model_strobe();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dut_c[k] !== m_active[k]) $display("FAIL midreset_next[%0d] got %h exp %h", k, dut_c[k], m_active[k]);
            else n_pass++;
        end
        n_checks++;
        if (upd_cnt !== exp_upd) $display("FAIL midreset_next_update got %0d exp %0d", upd_cnt, exp_upd); else n_pass++;
    endtask

    task automatic test_random();
        logic [79:0] rb, exp_rb, mask;
        for (int it = 0; it < 8; it++) begin
            logic [79:0] d = {16'($urandom), 32'($urandom), 32'($urandom)};
            int kind = int'($urandom_range(0, 3));
            int nbits = (kind < 2) ? 80 : (kind == 2) ? int'($urandom_range(1, 79)) : int'($urandom_range(81, 83));
            int ncmp = (nbits < 80) ? nbits : 80;
            exp_rb = active_word();
            mask = ~(80'h0);
            mask = mask << (80 - ncmp);
            shift_bits(d, nbits, 1'b1, 1'b1, rb);
            model_frame(d, nbits);
            n_checks++;
            if ((rb & mask) !== (exp_rb & mask)) $display("FAIL rand_readback it %0d got %h exp %h", it, rb & mask, exp_rb & mask);
            else n_pass++;
            if ($urandom_range(0, 2) != 0) begin
                do_strobe(); model_strobe();
            end
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (dut_c[k] !== m_active[k]) $display("FAIL rand_coeff it %0d [%0d] got %h exp %h", it, k, dut_c[k], m_active[k]);
                else n_pass++;
            end
            n_checks++;
            if (upd_cnt !== exp_upd) $display("FAIL rand_update it %0d got %0d exp %0d", it, upd_cnt, exp_upd); else n_pass++;
            n_checks++;
            if (err_cnt !== exp_err) $display("FAIL rand_error it %0d got %0d exp %0d", it, err_cnt, exp_err); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_readback();
        test_valid_frame();
        test_bad_frames();
        test_back_to_back();
        test_strobe_same_cycle();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_coeff_loader.md
Name: spi_coeff_loader

Overview:
- FPGA-side SPI responder that receives biquad coefficient frames from the MCU.
- Each frame carries five 16-bit Q2.14 words: b0, b1, b2, a1, a2.
- Holds the coefficients in a shadow bank and commits them atomically to the iir_filter coefficient inputs, only on a sample boundary, so the filter never runs with a mixed coefficient set.
- Returns the currently active coefficients on sdo for MCU readback.

Parameters:
- COEFF_W, 16, width of each coefficient word (Q2.14).
- SYNC_STAGES, 2, synchronizer depth for sck, sdi and cs_n.
- RESET_B0, 16384, reset value of b0 (1.0 in Q2.14; unity passthrough).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from MCU, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- sdi  input  1  SPI data from MCU, MSB first.
- cs_n  input  1  SPI chip select, active low.
- sdo  output  1  readback data to MCU.
- sample_strobe  input  1  one-cycle pulse marking an audio sample boundary.
- b0, b1, b2, a1, a2  output  COEFF_W each  signed active coefficients.
- coeff_update  output  1  one-cycle pulse when a new set is committed.
- frame_error  output  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:
- Reset values: b0=RESET_B0; b1=b2=a1=a2=0; sdo=0; coeff_update=0; frame_error=0. The pending flag, bit counter and shift register are cleared.
- Synchronizer resets: sck and sdi synchronizers reset to 0; cs_n synchronizer resets to 1.
- sck, sdi and cs_n each pass through SYNC_STAGES flops. Edges are detected on the synchronized sck and cs_n.
- Constraints on the MCU:
  - sck frequency must not exceed clk/8.
  - The MCU waits at least SYNC_STAGES+3 clk cycles between cs_n falling and the first sck rise.
- State machine:
  - WAIT_IDLE: entered on reset. Go to IDLE when synchronized cs_n is 1. This ignores any frame that was in progress during reset.
  - IDLE: on a synchronized cs_n falling edge:
    - clear the bit counter;
    - load the readback register with {b0,b1,b2,a1,a2} (80 bits, b0 MSB first);
    - go to SHIFT.
  - SHIFT, on each synchronized sck rising edge:
    - shift synchronized sdi into an 80-bit register from the LSB side;
    - bit counter increments, saturating at 81.
  - SHIFT, on each synchronized sck falling edge: shift the readback register left by one.
  - SHIFT, on synchronized cs_n rising edge:
    - counter == 80: copy the shift register to the shadow bank, set pending, go to IDLE.
    - counter != 80 (short or overrun frame): pulse frame_error for 1 cycle, leave shadow and pending unchanged, go to IDLE.
- sdo:
  - In SHIFT, sdo = readback register MSB. The first bit is valid before the first sck rise.
  - Outside SHIFT, sdo = 0.
- Commit:
  - In any cycle with sample_strobe=1 and pending=1 (pending as registered before that cycle), the shadow bank loads into b0..a2 on that clock edge.
  - pending clears on the same edge, and coeff_update pulses high for exactly the next cycle.
  - b0..a2 change at most once per sample_strobe and are never partially updated.
- Boundary cases:
  - A frame completing in the same cycle as sample_strobe is committed on the following strobe, not that one.
  - A second valid frame arriving before a commit overwrites the shadow bank. Only the latest set is committed.
  - sample_strobe with pending=0 has no effect.
  - sck edges in IDLE or WAIT_IDLE are ignored.
  - A cs_n pulse with zero sck edges produces a frame_error.
  - Reset asserted mid-frame: outputs return to reset values, the partial frame is dropped, no frame_error is raised, and the block stays in WAIT_IDLE until cs_n is high.
- Words are raw two's-complement and are not clamped. Range limiting is done on the MCU side.

Test Plan:
- Valid frame b0=0x2000, b1=0x4000, b2=0x2000, a1=0xC000, a2=0x1000, then sample_strobe -> no output change before the strobe; after it b0..a2 equal those words and coeff_update pulses exactly once.
- Readback: after reset, run an 80-bit frame with sdi=0 -> the first 16 sdo bits are 0x4000 and the remaining 64 bits are 0; then commit 0x0000 zeros.
- Short frame (79 bits) and overrun frame (81 bits) -> frame_error pulses once each; b0..a2 stay at their prior values; a following sample_strobe produces no coeff_update.
- Two valid frames (all 0x1111, then all 0x2222) before any strobe -> a single coeff_update; all outputs equal 0x2222.
- Frame end in the same cycle as sample_strobe -> no commit on that strobe; commit on the next strobe.
- Reset asserted after 40 bits with cs_n still low, then the remaining 40 bits sent and cs_n raised -> b0=0x4000, others 0, no frame_error, no coeff_update; the next full frame is accepted normally.
